// File: rtl/conv_3x3_channel_accum_pkg.sv
// conv_3x3_channel_accum_pkg
//   Shared parameters and helpers for the 3x3 convolution datapath.
//   Holds the default conv_3x3 geometry, the derived widths used by the
//   channel accumulator (IMAGE_SIZE, ACC_WIDTH, CNT_WIDTH_PIX, CNT_WIDTH_CH),
//   the accumulation phase type and the helpers that compute them.
package conv_3x3_channel_accum_pkg;

    // Default conv_3x3 geometry and number format
    localparam int DEFAULT_DATA_WIDTH     = 16;
    localparam int DEFAULT_IMAGE_WIDTH    = 16;
    localparam int DEFAULT_IMAGE_HEIGHT   = 16;
    localparam int DEFAULT_CHANNEL_NUM_IN = 512;
    localparam int DEFAULT_RELU           = 1;

    // Counter width that never collapses to zero bits, so a single-channel
    // or single-pixel configuration still elaborates to a legal vector.
    function automatic int cntWidth(input int count);
        if (count <= 1) begin
            return 1;
        end
        return $clog2(count);
    endfunction

    // Partial-sum width: wide enough that summing every input channel
    // (and then the bias) can never wrap.
    function automatic int accWidth(input int dataWidth, input int channels);
        return dataWidth + $clog2(channels) + 1;
    endfunction

    // Derived widths for the default configuration
    localparam int DEFAULT_IMAGE_SIZE    = DEFAULT_IMAGE_WIDTH * DEFAULT_IMAGE_HEIGHT;
    localparam int DEFAULT_ACC_WIDTH     = accWidth(DEFAULT_DATA_WIDTH, DEFAULT_CHANNEL_NUM_IN);
    localparam int DEFAULT_CNT_WIDTH_PIX = cntWidth(DEFAULT_IMAGE_SIZE);
    localparam int DEFAULT_CNT_WIDTH_CH  = cntWidth(DEFAULT_CHANNEL_NUM_IN);

    // What stage 2 does with a pixel:
    //   PH_FIRST : start a new partial sum (RAM contents ignored), write RAM
    //   PH_MID   : add to the stored partial sum, write RAM
    //   PH_LAST  : add to the stored partial sum, add bias, emit
    //   PH_ONLY  : single input channel, start fresh and emit immediately
    typedef enum logic [1:0] {
        PH_FIRST = 2'd0,
        PH_MID   = 2'd1,
        PH_LAST  = 2'd2,
        PH_ONLY  = 2'd3
    } phase_e;

    function automatic phase_e decodePhase(input int chIdx, input int channels);
        if (channels == 1) begin
            return PH_ONLY;
        end
        if (chIdx == 0) begin
            return PH_FIRST;
        end
        if (chIdx == channels - 1) begin
            return PH_LAST;
        end
        return PH_MID;
    endfunction

endpackage

// File: rtl/conv_3x3_channel_accum_psum_ram.sv
// psum_ram
//   Simple dual-port partial-sum memory, written so that synthesis maps it
//   onto block RAM: no reset, one synchronous write port and one synchronous
//   read port with a single cycle of read latency.
//
// Ports
//   clk_i       clock, rising edge
//   wrEn_i      write enable
//   wrAddr_i    write address
//   wrData_i    write data
//   rdEn_i      read enable; rdData_o updates on the following edge
//   rdAddr_i    read address
//   rdData_o    registered read data, holds while rdEn_i is low
module psum_ram #(
    parameter int DEPTH      = 256,
    parameter int WIDTH      = 26,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  wrEn_i,
    input  logic [ADDR_WIDTH-1:0] wrAddr_i,
    input  logic [WIDTH-1:0]      wrData_i,
    input  logic                  rdEn_i,
    input  logic [ADDR_WIDTH-1:0] rdAddr_i,
    output logic [WIDTH-1:0]      rdData_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            mem[wrAddr_i] <= wrData_i;
        end
    end

    // Read port, registered output
    always_ff @(posedge clk_i) begin
        if (rdEn_i) begin
            rdData_o <= mem[rdAddr_i];
        end
    end

endmodule

// File: rtl/conv_3x3_channel_accum.sv
// conv_3x3_channel_accum
//   Sums per-input-channel 3x3 results across CHANNEL_NUM_IN channels into a
//   single output-channel feature map. Partial sums live in psum_ram, one
//   entry per pixel. On the last input channel the partial sum, the current
//   pixel and the bias are added, saturated to DATA_WIDTH and optionally
//   passed through ReLU, then streamed out in raster order.
//
//   Two-stage pipeline:
//     stage 1: capture pixel, phase and address; launch the RAM read
//     stage 2: form the sum; write back (FIRST/MID) or emit (LAST)
//
// Ports
//   clk            clock, rising edge
//   reset          asynchronous reset, active low
//   valid_in       pxl_in valid this cycle
//   pxl_in         3x3 result for the current pixel / input channel
//   valid_bias_in  load bias_in into the bias register
//   bias_in        bias for the current output channel
//   pxl_out        finished output pixel, holds while valid_out is low
//   valid_out      pxl_out valid (2 cycles after the matching valid_in)
//   done_out       pulse with the last pixel of an output channel
module conv_3x3_channel_accum
    import conv_3x3_channel_accum_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int IMAGE_WIDTH    = DEFAULT_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT   = DEFAULT_IMAGE_HEIGHT,
    parameter int CHANNEL_NUM_IN = DEFAULT_CHANNEL_NUM_IN,
    parameter int RELU           = DEFAULT_RELU
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    input  logic                  valid_bias_in,
    input  logic [DATA_WIDTH-1:0] bias_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  done_out
);

    localparam int IMAGE_SIZE    = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int ACC_WIDTH     = accWidth(DATA_WIDTH, CHANNEL_NUM_IN);
    localparam int CNT_WIDTH_PIX = cntWidth(IMAGE_SIZE);
    localparam int CNT_WIDTH_CH  = cntWidth(CHANNEL_NUM_IN);
    // One extra bit so acc + bias is formed without any chance of wrapping
    localparam int SUM_WIDTH     = ACC_WIDTH + 1;

    localparam logic [CNT_WIDTH_PIX-1:0] PIX_LAST = CNT_WIDTH_PIX'(IMAGE_SIZE - 1);
    localparam logic [CNT_WIDTH_CH-1:0]  CH_LAST  = CNT_WIDTH_CH'(CHANNEL_NUM_IN - 1);

    // Largest / smallest DATA_WIDTH values, sign-extended to SUM_WIDTH
    localparam logic [SUM_WIDTH-1:0] SAT_MAX =
        {{(SUM_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic [SUM_WIDTH-1:0] SAT_MIN =
        {{(SUM_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    // Position counters
    logic [CNT_WIDTH_PIX-1:0] pixCnt_q, pixCnt_d;
    logic [CNT_WIDTH_CH-1:0]  chCnt_q,  chCnt_d;
    phase_e                   inPhase;

    // Stage 1 registers
    logic                     s1Valid_q;
    logic [DATA_WIDTH-1:0]    s1Pxl_q;
    phase_e                   s1Phase_q;
    logic [CNT_WIDTH_PIX-1:0] s1Addr_q;
    logic                     s1LastPix_q;

    // Bias register
    logic [DATA_WIDTH-1:0]    bias_q;

    // Stage 2 datapath
    logic [ACC_WIDTH-1:0]     ramRdData;
    logic [ACC_WIDTH-1:0]     pxlExt;
    logic [ACC_WIDTH-1:0]     accBase;
    logic [ACC_WIDTH-1:0]     accNew;
    logic [SUM_WIDTH-1:0]     sumWithBias;
    logic [DATA_WIDTH-1:0]    satValue;
    logic [DATA_WIDTH-1:0]    outValue;
    logic                     s2IsLast;
    logic                     ramWrEn;

    // Output registers
    logic [DATA_WIDTH-1:0]    pxlOut_q;
    logic                     validOut_q;
    logic                     doneOut_q;

    // Counter next-state: pixel counter wraps into the channel counter,
    // channel counter wrap starts the next output channel.
    always_comb begin
        pixCnt_d = pixCnt_q;
        chCnt_d  = chCnt_q;
        if (valid_in) begin
            if (pixCnt_q == PIX_LAST) begin
                pixCnt_d = '0;
                chCnt_d  = (chCnt_q == CH_LAST) ? '0 : chCnt_q + CNT_WIDTH_CH'(1);
            end else begin
                pixCnt_d = pixCnt_q + CNT_WIDTH_PIX'(1);
            end
        end
        inPhase = decodePhase(int'(chCnt_q), CHANNEL_NUM_IN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixCnt_q <= '0;
            chCnt_q  <= '0;
        end else begin
            pixCnt_q <= pixCnt_d;
            chCnt_q  <= chCnt_d;
        end
    end

    // Stage 1: capture the accepted pixel together with where it goes and
    // what stage 2 should do with it. The RAM read is launched in parallel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1Valid_q   <= 1'b0;
            s1Pxl_q     <= '0;
            s1Phase_q   <= PH_FIRST;
            s1Addr_q    <= '0;
            s1LastPix_q <= 1'b0;
        end else begin
            s1Valid_q <= valid_in;
            if (valid_in) begin
                s1Pxl_q     <= pxl_in;
                s1Phase_q   <= inPhase;
                s1Addr_q    <= pixCnt_q;
                s1LastPix_q <= (pixCnt_q == PIX_LAST);
            end
        end
    end

    // Bias register: the value held when a LAST pixel sits in stage 1 is
    // the one added, so upstream may reload it once done_out is seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bias_q <= '0;
        end else if (valid_bias_in) begin
            bias_q <= bias_in;
        end
    end

    // A pixel's partial sum is re-read only a full image later, so the
    // write of one channel never collides with the read of the next and
    // no forwarding path is needed.
    psum_ram #(
        .DEPTH      (IMAGE_SIZE),
        .WIDTH      (ACC_WIDTH),
        .ADDR_WIDTH (CNT_WIDTH_PIX)
    ) u_psum_ram (
        .clk_i    (clk),
        .wrEn_i   (ramWrEn),
        .wrAddr_i (s1Addr_q),
        .wrData_i (accNew),
        .rdEn_i   (valid_in),
        .rdAddr_i (pixCnt_q),
        .rdData_o (ramRdData)
    );

    // Stage 2 arithmetic. The first channel ignores whatever the RAM holds,
    // which is also why the RAM never needs clearing.
    always_comb begin
        s2IsLast = (s1Phase_q == PH_LAST) || (s1Phase_q == PH_ONLY);
        ramWrEn  = s1Valid_q && !s2IsLast;

        pxlExt  = {{(ACC_WIDTH - DATA_WIDTH){s1Pxl_q[DATA_WIDTH-1]}}, s1Pxl_q};
        accBase = ((s1Phase_q == PH_FIRST) || (s1Phase_q == PH_ONLY)) ? '0 : ramRdData;
        accNew  = accBase + pxlExt;

        sumWithBias = {accNew[ACC_WIDTH-1], accNew}
                    + {{(SUM_WIDTH - DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};

        if ($signed(sumWithBias) > $signed(SAT_MAX)) begin
            satValue = SAT_MAX[DATA_WIDTH-1:0];
        end else if ($signed(sumWithBias) < $signed(SAT_MIN)) begin
            satValue = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            satValue = sumWithBias[DATA_WIDTH-1:0];
        end

        outValue = satValue;
        if ((RELU != 0) && satValue[DATA_WIDTH-1]) begin
            outValue = '0;
        end
    end

    // Output registers; pxl_out only moves when a finished pixel is emitted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pxlOut_q   <= '0;
            validOut_q <= 1'b0;
            doneOut_q  <= 1'b0;
        end else begin
            validOut_q <= s1Valid_q && s2IsLast;
            doneOut_q  <= s1Valid_q && s2IsLast && s1LastPix_q;
            if (s1Valid_q && s2IsLast) begin
                pxlOut_q <= outValue;
            end
        end
    end

    assign pxl_out   = pxlOut_q;
    assign valid_out = validOut_q;
    assign done_out  = doneOut_q;

endmodule

// File: tb/tb_conv_3x3_channel_accum.sv
// tb_conv_3x3_channel_accum
//   Directed bench for conv_3x3_channel_accum on a 4x4 map with three input
//   channels. Two instances share every input: one with ReLU, one without.
//   Each scenario task drives a stream and compares the collected outputs
//   against hand-computed values.
module tb_conv_3x3_channel_accum;

    localparam int DW   = 16;
    localparam int CH   = 3;
    localparam int NPIX = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [DW-1:0] pxl_in;
    logic          valid_bias_in;
    logic [DW-1:0] bias_in;
    logic [DW-1:0] pxl_out;
    logic          valid_out;
    logic          done_out;
    logic [DW-1:0] nrPxlOut;
    logic          nrValidOut;
    logic          nrDoneOut;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Output log filled by the monitor
    logic [DW-1:0] outQ[$];
    logic [DW-1:0] nrOutQ[$];
    logic          doneQ[$];
    int            outCycQ[$];
    int            inCycQ[$];
    int            strayDone = 0;

    conv_3x3_channel_accum #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
        .CHANNEL_NUM_IN(CH), .RELU(1)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
        .valid_bias_in(valid_bias_in), .bias_in(bias_in),
        .pxl_out(pxl_out), .valid_out(valid_out), .done_out(done_out)
    );

    conv_3x3_channel_accum #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
        .CHANNEL_NUM_IN(CH), .RELU(0)
    ) dutNoRelu (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
        .valid_bias_in(valid_bias_in), .bias_in(bias_in),
        .pxl_out(nrPxlOut), .valid_out(nrValidOut), .done_out(nrDoneOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample away from the active edge
    always @(negedge clk) begin
        if (valid_out) begin
            outQ.push_back(pxl_out);
            nrOutQ.push_back(nrPxlOut);
            doneQ.push_back(done_out);
            outCycQ.push_back(cyc);
        end
        if (done_out && !valid_out) strayDone++;
        if (nrValidOut !== valid_out) strayDone++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [DW-1:0] pixVal(input int mode, input int c, input int p);
        case (mode)
            0:       return DW'(c + 1);
            1:       return 16'h7FFF;
            2:       return 16'hFFFE;
            3:       return DW'(p + 16 * c);
            4:       return 16'd100;
            5:       return DW'(p + c);
            6:       return DW'(p * 10 + c);
            default: return '0;
        endcase
    endfunction

    task automatic clearLog();
        outQ.delete(); nrOutQ.delete(); doneQ.delete();
        outCycQ.delete(); inCycQ.delete();
        strayDone = 0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
            pxl_in   = DW'($urandom);
        end
    endtask

    // Drive one pixel after an optional bubble; returns the cycle it was driven in
    task automatic applyStimulus(input logic [DW-1:0] v, input int gap, output int drvCyc);
        idleCycles(gap);
        @(posedge clk); #1;
        valid_in = 1'b1;
        pxl_in   = v;
        drvCyc   = cyc;
    endtask

    task automatic loadBias(input logic [DW-1:0] b);
        @(posedge clk); #1;
        valid_bias_in = 1'b1;
        bias_in       = b;
        @(posedge clk); #1;
        valid_bias_in = 1'b0;
        bias_in       = DW'($urandom);
    endtask

    // Channel-major stream; limit < 0 sends all CH*NPIX pixels
    task automatic runStream(input int mode, input int maxGap, input int limit);
        int c, p, gap, dc;
        for (int i = 0; i < CH * NPIX; i++) begin
            if (limit >= 0 && i >= limit) break;
            c   = i / NPIX;
            p   = i % NPIX;
            gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
            applyStimulus(pixVal(mode, c, p), gap, dc);
            if (c == CH - 1) inCycQ.push_back(dc);
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        reset = 1'b1;
        #2 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            valid_in      = 1'($urandom);
            pxl_in        = DW'($urandom);
            valid_bias_in = 1'($urandom);
            bias_in       = DW'($urandom);
            @(negedge clk);
            checks++;
            if (pxl_out !== '0) begin
                failures++; $display("[TB] FAIL reset_pxl_out got=%h expected=0000", pxl_out);
            end
            checks++;
            if (valid_out !== 1'b0) begin
                failures++; $display("[TB] FAIL reset_valid_out got=%b expected=0", valid_out);
            end
            checks++;
            if (done_out !== 1'b0) begin
                failures++; $display("[TB] FAIL reset_done_out got=%b expected=0", done_out);
            end
        end
        @(posedge clk); #1;
        valid_in = 1'b0; valid_bias_in = 1'b0;
        reset = 1'b1;
        clearLog();
        idleCycles(3);
        checks++;
        if (outQ.size() != 0) begin
            failures++; $display("[TB] FAIL reset_idle_outputs got=%0d expected=0", outQ.size());
        end
    endtask

    task automatic test_basic_sum();
        int n;
        $display("[TB] test_basic_sum");
        loadBias(16'd10);
        clearLog();
        runStream(0, 0, -1);
        idleCycles(4);
        checks++;
        if (outQ.size() != NPIX) begin
            failures++; $display("[TB] FAIL basic_count got=%0d expected=%0d", outQ.size(), NPIX);
        end
        n = (outQ.size() < inCycQ.size()) ? outQ.size() : inCycQ.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (outQ[i] !== 16'd16) begin
                failures++; $display("[TB] FAIL basic_value idx=%0d got=%h expected=0010", i, outQ[i]);
            end
            checks++;
            if (doneQ[i] !== (i == NPIX - 1)) begin
                failures++; $display("[TB] FAIL basic_done idx=%0d got=%b expected=%b", i, doneQ[i], i == NPIX - 1);
            end
            checks++;
            if (outCycQ[i] != inCycQ[i] + 2) begin
                failures++; $display("[TB] FAIL basic_latency idx=%0d got=%0d expected=%0d", i, outCycQ[i], inCycQ[i] + 2);
            end
        end
        checks++;
        if (strayDone != 0) begin
            failures++; $display("[TB] FAIL basic_stray_done got=%0d expected=0", strayDone);
        end
    endtask

    task automatic test_saturation_relu();
        $display("[TB] test_saturation_relu");
        loadBias(16'h7FFF);
        clearLog();
        runStream(1, 0, -1);
        idleCycles(4);
        checks++;
        if (outQ.size() != NPIX) begin
            failures++; $display("[TB] FAIL sat_count got=%0d expected=%0d", outQ.size(), NPIX);
        end
        for (int i = 0; i < outQ.size() && i < NPIX; i++) begin
            checks++;
            if (outQ[i] !== 16'h7FFF || nrOutQ[i] !== 16'h7FFF) begin
                failures++; $display("[TB] FAIL sat_pos idx=%0d got=%h/%h expected=7fff/7fff", i, outQ[i], nrOutQ[i]);
            end
        end
        loadBias(16'd1);
        clearLog();
        runStream(2, 0, -1);
        idleCycles(4);
        checks++;
        if (outQ.size() != NPIX) begin
            failures++; $display("[TB] FAIL relu_count got=%0d expected=%0d", outQ.size(), NPIX);
        end
        for (int i = 0; i < outQ.size() && i < NPIX; i++) begin
            checks++;
            if (outQ[i] !== 16'h0000) begin
                failures++; $display("[TB] FAIL relu_on idx=%0d got=%h expected=0000", i, outQ[i]);
            end
            checks++;
            if (nrOutQ[i] !== 16'hFFFB) begin
                failures++; $display("[TB] FAIL relu_off idx=%0d got=%h expected=fffb", i, nrOutQ[i]);
            end
        end
    endtask

    task automatic test_gapped();
        int n;
        logic [DW-1:0] expv;
        $display("[TB] test_gapped");
        loadBias(16'd7);
        clearLog();
        runStream(3, 3, -1);
        idleCycles(4);
        checks++;
        if (outQ.size() != NPIX) begin
            failures++; $display("[TB] FAIL gap_count got=%0d expected=%0d", outQ.size(), NPIX);
        end
        n = (outQ.size() < inCycQ.size()) ? outQ.size() : inCycQ.size();
        for (int i = 0; i < n; i++) begin
            expv = DW'(3 * i + 55);
            checks++;
            if (outQ[i] !== expv) begin
                failures++; $display("[TB] FAIL gap_value idx=%0d got=%h expected=%h", i, outQ[i], expv);
            end
            checks++;
            if (outCycQ[i] != inCycQ[i] + 2) begin
                failures++; $display("[TB] FAIL gap_latency idx=%0d got=%0d expected=%0d", i, outCycQ[i], inCycQ[i] + 2);
            end
        end
        checks++;
        if (doneQ.size() == NPIX && doneQ[NPIX-1] !== 1'b1) begin
            failures++; $display("[TB] FAIL gap_done got=%b expected=1", doneQ[NPIX-1]);
        end
    endtask

    task automatic test_reset_midstream();
        logic [DW-1:0] expv;
        $display("[TB] test_reset_midstream");
        loadBias(16'd50);
        clearLog();
        runStream(4, 0, NPIX + 7);
        @(posedge clk); #1;
        reset = 1'b0;
        valid_in = 1'b1;
        pxl_in = DW'($urandom);
        repeat (2) @(negedge clk);
        checks++;
        if (valid_out !== 1'b0 || pxl_out !== '0 || done_out !== 1'b0) begin
            failures++; $display("[TB] FAIL midreset_outputs got=%b/%h/%b expected=0/0000/0", valid_out, pxl_out, done_out);
        end
        checks++;
        if (outQ.size() != 0) begin
            failures++; $display("[TB] FAIL midreset_early_out got=%0d expected=0", outQ.size());
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        reset = 1'b1;
        clearLog();
        // Bias was cleared by reset and is not reloaded
        runStream(5, 0, -1);
        idleCycles(4);
        checks++;
        if (outQ.size() != NPIX) begin
            failures++; $display("[TB] FAIL midreset_count got=%0d expected=%0d", outQ.size(), NPIX);
        end
        for (int i = 0; i < outQ.size() && i < NPIX; i++) begin
            expv = DW'(3 * i + 3);
            checks++;
            if (outQ[i] !== expv) begin
                failures++; $display("[TB] FAIL midreset_value idx=%0d got=%h expected=%h", i, outQ[i], expv);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        int p;
        logic [DW-1:0] expR, expN;
        $display("[TB] test_back_to_back");
        loadBias(16'd5);
        clearLog();
        seen = 1'b0;
        fork
            begin
                runStream(6, 0, -1);
                runStream(6, 0, -1);
            end
            begin
                for (int k = 0; k < 300; k++) begin
                    @(negedge clk);
                    if (done_out) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (seen) loadBias(-16'sd5);
            end
        join
        idleCycles(4);
        checks++;
        if (!seen) begin
            failures++; $display("[TB] FAIL b2b_first_done got=timeout expected=pulse");
        end
        checks++;
        if (outQ.size() != 2 * NPIX) begin
            failures++; $display("[TB] FAIL b2b_count got=%0d expected=%0d", outQ.size(), 2 * NPIX);
        end
        for (int i = 0; i < outQ.size() && i < 2 * NPIX; i++) begin
            p = i % NPIX;
            if (i < NPIX) begin
                expN = DW'(30 * p + 8);
                expR = expN;
            end else begin
                expN = DW'(30 * p - 2);
                expR = (p == 0) ? 16'h0000 : expN;
            end
            checks++;
            if (outQ[i] !== expR || nrOutQ[i] !== expN) begin
                failures++; $display("[TB] FAIL b2b_value idx=%0d got=%h/%h expected=%h/%h", i, outQ[i], nrOutQ[i], expR, expN);
            end
            checks++;
            if (doneQ[i] !== (p == NPIX - 1)) begin
                failures++; $display("[TB] FAIL b2b_done idx=%0d got=%b expected=%b", i, doneQ[i], p == NPIX - 1);
            end
        end
        checks++;
        if (strayDone != 0) begin
            failures++; $display("[TB] FAIL b2b_stray_done got=%0d expected=0", strayDone);
        end
    endtask

    initial begin
        reset         = 1'b1;
        valid_in      = 1'b0;
        pxl_in        = '0;
        valid_bias_in = 1'b0;
        bias_in       = '0;
        test_reset();
        test_basic_sum();
        test_saturation_relu();
        test_gapped();
        test_reset_midstream();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_3x3_channel_accum.md
# conv_3x3_channel_accum

Downstream stage of the 3x3 convolution top. It consumes the per-input-channel 3x3 results (`pxl_out`/`valid_out`) and sums them across `CHANNEL_NUM_IN` input channels into one output-channel feature map, using an on-chip partial-sum RAM. After the last input channel it adds a per-output-channel bias, saturates, and optionally applies ReLU. It streams the finished map in raster order to the next layer or the store path.

## Interface
- `DATA_WIDTH`, 16: signed two's-complement pixel/bias width. Input and output share one fixed-point format.
- `IMAGE_WIDTH`, 16: map width.
- `IMAGE_HEIGHT`, 16: map height.
- `CHANNEL_NUM_IN`, 512: input channels summed per output channel.
- `RELU`, 1: 1 clamps negative results to 0; 0 passes them through.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `valid_in`  in  1: `pxl_in` valid this cycle.
- `pxl_in`  in  DATA_WIDTH: 3x3 result for the current pixel and input channel.
- `valid_bias_in`  in  1: load `bias_in` into the bias register.
- `bias_in`  in  DATA_WIDTH: bias for the current output channel.
- `pxl_out`  out  DATA_WIDTH: finished output pixel.
- `valid_out`  out  1: `pxl_out` valid.
- `done_out`  out  1: one-cycle pulse, coincident with the last pixel of an output channel.

## Operation
- Input order: the stream arrives channel-major. All `IMAGE_SIZE = IMAGE_WIDTH*IMAGE_HEIGHT` pixels of input channel c come in raster order, then channel c+1.
- Flow control: none. `valid_in` may drop on any cycle; gaps only stall the counters.
- Counters:
  - `pix_cnt` runs 0..IMAGE_SIZE-1 and increments on each accepted pixel.
  - When `pix_cnt` wraps, `ch_cnt` increments over 0..CHANNEL_NUM_IN-1.
  - When `ch_cnt` wraps, both counters return to 0 and the next output channel begins.
- Phases, decoded from `ch_cnt`:
  - FIRST (c=0): write the sign-extended `pxl_in` to RAM[pix].
  - MID (0<c<last): write RAM[pix]+`pxl_in` to RAM[pix].
  - LAST (c=CHANNEL_NUM_IN-1): compute RAM[pix]+`pxl_in`+bias, skip the RAM write, and emit the result.
  - With CHANNEL_NUM_IN=1, FIRST and LAST coincide: output is `pxl_in`+bias.
- Arithmetic:
  - ACC_WIDTH = DATA_WIDTH + clog2(CHANNEL_NUM_IN) + 1. The RAM stores ACC_WIDTH bits and the accumulator never overflows internally.
  - Output = sat_DATA_WIDTH(acc + bias), then ReLU if RELU=1.
  - Saturation limits are 0x7FFF and 0x8000 for the default width.
- Bias register:
  - Loads on `valid_bias_in` and holds between loads.
  - The value present when a LAST-phase pixel enters stage 2 is the one used.
  - Upstream loads the next bias after `done_out`.
- RAM hazard: an address is re-read no earlier than IMAGE_SIZE accepted pixels after its write. IMAGE_SIZE >= 4 is required and needs no forwarding.
- Reset, at any time including mid-channel:
  - Counters, bias register and all pipeline valids go to 0.
  - `pxl_out`, `valid_out` and `done_out` go to 0.
  - RAM contents are not cleared; the FIRST phase overwrites them.
  - Any partially accumulated output channel is discarded. The next accepted pixel is pixel 0 of channel 0.

## Timing
- Stage 1 (edge after `valid_in`): register `pxl_in`, phase and address; issue the RAM read.
- Stage 2 (next edge): form the sum; write RAM (FIRST/MID) or register `pxl_out`/`valid_out` (LAST).
- Latency: `valid_out` goes high 2 cycles after the corresponding `valid_in` cycle.
- Throughput: one pixel per cycle, sustained.
- `done_out` is high in the same cycle as `valid_out` for pixel IMAGE_SIZE-1 of the LAST phase.
- `pxl_out` holds its last value when `valid_out` is low.

## Structure
- Shared parameter include/package holds `IMAGE_SIZE`, `ACC_WIDTH`, `CNT_WIDTH_PIX = clog2(IMAGE_SIZE)` and `CNT_WIDTH_CH = clog2(CHANNEL_NUM_IN)`, alongside the existing conv_3x3 parameter definitions.
- One sub-module, `psum_ram`: simple dual-port RAM, IMAGE_SIZE x ACC_WIDTH, one synchronous write port, one synchronous read port with 1-cycle read latency. It must infer as block RAM.
- Top-level logic holds the counters, phase decode, adder, saturation, ReLU and bias register.

## Test plan
All scenarios use IMAGE 4x4 (16 pixels) and CHANNEL_NUM_IN=3 unless stated otherwise.
- Reset: hold `reset`=0 with random inputs -> `pxl_out`=0, `valid_out`=0, `done_out`=0; first output after release is 2 cycles after the first `valid_in`.
- Basic sum: bias=10; channels carry constant 1, 2, 3 -> 16 outputs of 16; `done_out` on the 16th; no outputs during channels 0 and 1.
- Saturation and ReLU:
  - Inputs 0x7FFF on all channels, bias 0x7FFF -> 0x7FFF.
  - Inputs -2 per channel, bias 1 -> 0 with RELU=1; 0xFFFB with RELU=0.
- Gapped input: random 0-3 cycle bubbles on `valid_in`, per-pixel values p+16c -> identical results to the gapless run; each `valid_out` exactly 2 cycles after its `valid_in`.
- Reset mid-stream: assert reset at channel 1, pixel 7, then replay a full 3-channel stream -> outputs reflect only the replayed data.
- Back-to-back output channels: bias 5 then bias -5, loaded after each `done_out`, two streams -> second map equals first map minus 10.
